mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Memory-stage load/store unit. Consumes the E/M register outputs (ALUResultM, WriteDataM, Func3M)
//  plus MemReadM/MemWriteM, drives the data-memory req/ack bus and aligns load data for the M/W register.
//  Stalls the pipeline on memory wait states, flags misaligned/illegal accesses, and times out dead bus transfers.
// PARAMETERS
//  TIMEOUT  16  max request cycles without ack before AccessErrM (>=2); counter width $clog2(TIMEOUT+1)
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-high reset
//  MemReadM    in   1   load in M
//  MemWriteM   in   1   store in M
//  Func3M      in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ALUResultM  in   32  byte address
//  WriteDataM  in   32  store data, right-justified
//  HoldM       in   1   external freeze of the M stage (hazard unit)
//  StallM      out  1   freeze PC and F/D/E/M registers this cycle
//  ReadDataM   out  32  aligned, extended load data to the M/W register
//  MisalignM   out  1   misaligned access; no bus transfer
//  AccessErrM  out  1   illegal Func3, read+write together, or timeout
//  dmem_req    out  1   request; held until ack or timeout
//  dmem_we     out  1   1 = write
//  dmem_addr   out  32  {ALUResultM[31:2],2'b00}
//  dmem_wdata  out  32  lane-replicated store data
//  dmem_be     out  4   byte enables
//  dmem_ack    in   1   transfer done; dmem_rdata valid in the same cycle
//  dmem_rdata  in   32  read word
// BEHAVIOUR
//  - Access = MemReadM|MemWriteM. Misalign: H/HU with addr[0]=1; W with addr[1:0]!=0.
//    Illegal: Func3 in {011,110,111}, stores with Func3[2]=1, or MemReadM&MemWriteM.
//    Misaligned or illegal access: no req, StallM=0, ReadDataM=0, flag asserted combinationally while in M.
//  - Store: SB be=0001<<a[1:0], wdata={4{d[7:0]}}; SH be=0011<<a[1:0], wdata={2{d[15:0]}}; SW be=1111.
//    Load: be=1111, we=0. The byte/half is selected by a[1:0], then sign-extended (B/H) or zero-extended (BU/HU).
//  - FSM IDLE/WAIT/DONE, counter cnt:
//    IDLE: a valid access asserts dmem_req in the same cycle (zero added latency).
//      If ack arrives that cycle: StallM=0, ReadDataM comes from the ack data. Go to DONE if HoldM, else stay in IDLE.
//      If there is no ack: StallM=1, go to WAIT, cnt<=1.
//    WAIT: req held with stable addr/we/be/wdata; StallM=1; cnt++ on each cycle without ack.
//      On ack: StallM=0, data passes through. Go to DONE if HoldM, else to IDLE.
//      Timeout cycle is cnt==TIMEOUT: req=0, StallM=0, AccessErrM=1, ReadDataM=0; ack is ignored.
//      Then go to DONE if HoldM, else to IDLE.
//    DONE: the instruction is held by HoldM after completion. req=0, StallM=0.
//      ReadDataM/AccessErrM come from capture registers loaded at completion. Go to IDLE when HoldM=0.
//  - Zero-wait access with HoldM=1 in IDLE goes to DONE, so a held access never re-issues.
//  - HoldM has no effect on an in-flight WAIT other than choosing the exit state.
//  - Reset values (reset cycle and after): state=IDLE, cnt=0, capture regs=0.
//    dmem_req=0, StallM=0, ReadDataM=0, MisalignM=0, AccessErrM=0 while reset=1.
//    Reset mid-WAIT abandons the transfer; a late ack in IDLE with no access is ignored.
//  - dmem_addr/we/be/wdata are combinational from M inputs; they are don't-care when req=0.
// STRUCTURE
//  - Shared header lsu_defs.vh: Func3 codes (F3_B,F3_H,F3_W,F3_BU,F3_HU), state encodings (2-bit), BE patterns.
//  - Sub-module mem_load_align (combinational: rdata, a[1:0], Func3 -> 32b result).
//    Used for both the live path and the capture path.
//  - Top holds the FSM, timeout counter, capture registers, store lane logic.
// TESTING
//  1. LW a=0x100, ack same cycle, rdata=0xDEADBEEF -> req 1 cycle, ReadDataM=0xDEADBEEF, StallM never 1.
//  2. LB a=0x103, rdata=0x80FF_FF7F, ack after 2 wait cycles -> dmem_addr=0x100, StallM=1 for 2 cycles, ReadDataM=0xFFFFFF80.
//     Repeat as LBU -> 0x00000080.
//  3. SH a=0x22, WriteDataM=0x1234ABCD, ack same cycle -> we=1, addr=0x20, be=1100, wdata=0xABCDABCD.
//  4. LW a=0x102 -> MisalignM=1, req=0, StallM=0, ReadDataM=0. Func3=011 load -> AccessErrM=1, req=0.
//  5. TIMEOUT=4, LW without ack -> req high 4 cycles, StallM high 4 cycles.
//     5th cycle: req=0, StallM=0, AccessErrM=1. Ack injected in the 5th cycle is ignored.
//  6. LW ack in cycle 2 with HoldM=1 for 3 more cycles -> no second req, ReadDataM/AccessErrM stable from capture.
//     Reset asserted in WAIT -> next cycle req=0, state IDLE.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage LSU: Func3 codes, FSM states, byte-enable patterns.
// Also holds the small decode helpers used by the top.
package mem_stage_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } lsu_state_t;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Halfwords (signed or unsigned) need even addresses, words need 4-byte alignment.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == F3_H || f3 == F3_HU) && off[0]) || (f3 == F3_W && off != 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load aligner: picks the byte/half addressed by off and sign/zero extends it.
// Used for both the live ack path and the completion capture path.
module mem_load_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  f3,
    output logic [31:0] result
);

    logic [31:0] sh;

    always_comb begin
        sh = rdata >> {off, 3'b000};
        case (f3)
            F3_B:    result = {{24{sh[7]}}, sh[7:0]};
            F3_H:    result = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   result = {24'd0, sh[7:0]};
            F3_HU:   result = {16'd0, sh[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues req/ack bus transfers, stalls on wait states,
// flags misaligned/illegal accesses and times out dead transfers.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Func3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        HoldM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        AccessErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_t  state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic [31:0] cap_rdata;
    logic [1:0]  cap_off;
    logic [2:0]  cap_f3;
    logic        cap_ld;
    logic        cap_err;
    logic        cap_load;
    logic        cap_timeout;

    logic        access, illegal, misal, go;
    logic [1:0]  off;
    logic [31:0] live_align, cap_align;
    logic        req, stall, misal_o, err_o;
    logic [31:0] rdata_o;

    assign off     = ALUResultM[1:0];
    assign access  = MemReadM | MemWriteM;
    assign illegal = f3_illegal(Func3M) | (MemWriteM & Func3M[2]) | (MemReadM & MemWriteM);
    assign misal   = f3_misaligned(Func3M, off);
    assign go      = access & ~illegal & ~misal;

    mem_load_align u_live_align (
        .rdata  (dmem_rdata),
        .off    (off),
        .f3     (Func3M),
        .result (live_align)
    );

    mem_load_align u_cap_align (
        .rdata  (cap_rdata),
        .off    (cap_off),
        .f3     (cap_f3),
        .result (cap_align)
    );

    // Store lanes: replicate data across the word so the byte enables alone pick the target lanes.
    always_comb begin
        dmem_be    = BE_W;
        dmem_wdata = WriteDataM;
        if (MemWriteM) begin
            case (Func3M[1:0])
                2'b00: begin
                    dmem_be    = BE_B << off;
                    dmem_wdata = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    dmem_be    = BE_H << off;
                    dmem_wdata = {2{WriteDataM[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign dmem_addr = {ALUResultM[31:2], 2'b00};
    assign dmem_we   = MemWriteM;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        req         = 1'b0;
        stall       = 1'b0;
        misal_o     = 1'b0;
        err_o       = 1'b0;
        rdata_o     = 32'd0;
        cap_load    = 1'b0;
        cap_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                misal_o = access & misal;
                err_o   = access & illegal;
                if (go) begin
                    req = 1'b1;
                    if (dmem_ack) begin
                        rdata_o   = MemReadM ? live_align : 32'd0;
                        cap_load  = 1'b1;
                        state_nxt = HoldM ? S_DONE : S_IDLE;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = S_WAIT;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == CW'(TIMEOUT)) begin
                    // Timeout wins over a coincident ack: the transfer is already declared dead.
                    err_o       = 1'b1;
                    cap_load    = 1'b1;
                    cap_timeout = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = HoldM ? S_DONE : S_IDLE;
                end else begin
                    req = 1'b1;
                    if (dmem_ack) begin
                        rdata_o   = MemReadM ? live_align : 32'd0;
                        cap_load  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = HoldM ? S_DONE : S_IDLE;
                    end else begin
                        stall   = 1'b1;
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            S_DONE: begin
                rdata_o = cap_ld ? cap_align : 32'd0;
                err_o   = cap_err;
                if (!HoldM) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cap_rdata <= 32'd0;
            cap_off   <= 2'd0;
            cap_f3    <= 3'd0;
            cap_ld    <= 1'b0;
            cap_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (cap_load) begin
                cap_rdata <= cap_timeout ? 32'd0 : dmem_rdata;
                cap_off   <= off;
                cap_f3    <= Func3M;
                cap_ld    <= MemReadM & ~cap_timeout;
                cap_err   <= cap_timeout;
            end
        end
    end

    assign dmem_req   = req & ~reset;
    assign StallM     = stall & ~reset;
    assign MisalignM  = misal_o & ~reset;
    assign AccessErrM = err_o & ~reset;
    assign ReadDataM  = reset ? 32'd0 : rdata_o;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with TIMEOUT=4; inputs driven 1ns after posedge, outputs sampled at negedge.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM, HoldM, dmem_ack;
    logic [2:0]  Func3M;
    logic [31:0] ALUResultM, WriteDataM, dmem_rdata;
    logic        StallM, MisalignM, AccessErrM, dmem_req, dmem_we;
    logic [31:0] ReadDataM, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Func3M     (Func3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .HoldM      (HoldM),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .MisalignM  (MisalignM),
        .AccessErrM (AccessErrM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic hold, input logic ack, input logic [31:0] rdat);
        MemReadM   = rd;
        MemWriteM  = wr;
        Func3M     = f3;
        ALUResultM = a;
        WriteDataM = wd;
        HoldM      = hold;
        dmem_ack   = ack;
        dmem_rdata = rdat;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        // Reset with a live access and ack present: everything must stay quiet.
        drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(StallM), 32'd0);
        check("rst_rdata", ReadDataM, 32'd0);
        check("rst_flags", {30'd0, MisalignM, AccessErrM}, 32'd0);
        next();
        reset = 1'b0;
        idle();
        @(negedge clk);

        // LW zero-wait
        next();
        drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        check("lw_req", 32'(dmem_req), 32'd1);
        check("lw_stall", 32'(StallM), 32'd0);
        check("lw_rdata", ReadDataM, 32'hDEADBEEF);
        check("lw_addr", dmem_addr, 32'h100);
        check("lw_be_we", {27'd0, dmem_we, dmem_be}, 32'h0F);
        next();
        idle();
        @(negedge clk);
        check("lw_req_drop", 32'(dmem_req), 32'd0);

        // LB / LBU at 0x103 with two wait cycles
        for (int k = 0; k < 2; k++) begin
            next();
            drive(1'b1, 1'b0, (k == 0) ? 3'b000 : 3'b100, 32'h103, 32'h0, 1'b0, 1'b0, 32'h80FFFF7F);
            @(negedge clk);
            check("lb_w1_stall", {30'd0, dmem_req, StallM}, 32'h3);
            check("lb_addr", dmem_addr, 32'h100);
            next();
            @(negedge clk);
            check("lb_w2_stall", {30'd0, dmem_req, StallM}, 32'h3);
            next();
            dmem_ack = 1'b1;
            @(negedge clk);
            check("lb_ack_stall", 32'(StallM), 32'd0);
            check("lb_rdata", ReadDataM, (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
        end

        // SH 0x22
        next();
        drive(1'b0, 1'b1, 3'b001, 32'h22, 32'h1234ABCD, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        check("sh_req_we", {30'd0, dmem_req, dmem_we}, 32'h3);
        check("sh_addr", dmem_addr, 32'h20);
        check("sh_be", 32'(dmem_be), 32'hC);
        check("sh_wdata", dmem_wdata, 32'hABCDABCD);
        check("sh_stall", 32'(StallM), 32'd0);

        // SB 0x101
        next();
        drive(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000775A, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        check("sb_be", 32'(dmem_be), 32'h2);
        check("sb_wdata", dmem_wdata, 32'h5A5A5A5A);

        // LH / LHU at 0x102
        next();
        drive(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1'b0, 1'b1, 32'h80011234);
        @(negedge clk);
        check("lh_rdata", ReadDataM, 32'hFFFF8001);
        next();
        Func3M = 3'b101;
        @(negedge clk);
        check("lhu_rdata", ReadDataM, 32'h00008001);

        // Misaligned and illegal accesses
        next();
        drive(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1'b0, 1'b1, 32'h12345678);
        @(negedge clk);
        check("mis_flag", {30'd0, MisalignM, AccessErrM}, 32'h2);
        check("mis_req_stall", {30'd0, dmem_req, StallM}, 32'h0);
        check("mis_rdata", ReadDataM, 32'd0);
        next();
        drive(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("f3_011_flags", {30'd0, MisalignM, AccessErrM}, 32'h1);
        check("f3_011_req", 32'(dmem_req), 32'd0);
        next();
        drive(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("rw_both_err", {30'd0, dmem_req, AccessErrM}, 32'h1);
        next();
        drive(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("sbu_err", {30'd0, dmem_req, AccessErrM}, 32'h1);

        // Timeout after 4 request cycles; ack in the 5th is ignored
        next();
        drive(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("to_cyc%0d", i + 1), {30'd0, dmem_req, StallM}, 32'h3);
            next();
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h55555555;
        @(negedge clk);
        check("to_req_stall", {30'd0, dmem_req, StallM}, 32'h0);
        check("to_err", 32'(AccessErrM), 32'd1);
        check("to_rdata", ReadDataM, 32'd0);
        next();
        idle();
        @(negedge clk);
        check("to_after", {30'd0, dmem_req, AccessErrM}, 32'h0);

        // Ack on cycle 2 while held: capture must hold the result with no reissue
        next();
        drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("hold_w1", {30'd0, dmem_req, StallM}, 32'h3);
        next();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h11223344;
        @(negedge clk);
        check("hold_ack_rdata", ReadDataM, 32'h11223344);
        check("hold_ack_stall", 32'(StallM), 32'd0);
        for (int i = 0; i < 3; i++) begin
            next();
            dmem_ack   = 1'b0;
            dmem_rdata = 32'hFFFFFFFF;
            @(negedge clk);
            check($sformatf("hold_d%0d_req", i), {30'd0, dmem_req, StallM}, 32'h0);
            check($sformatf("hold_d%0d_rdata", i), ReadDataM, 32'h11223344);
            check($sformatf("hold_d%0d_err", i), 32'(AccessErrM), 32'd0);
        end
        next();
        idle();
        @(negedge clk);
        check("hold_release_rdata", ReadDataM, 32'h11223344);
        next();
        @(negedge clk);
        check("hold_idle_rdata", ReadDataM, 32'd0);

        // Timeout while held: the error stays visible from the capture register
        next();
        drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) next();
        @(negedge clk);
        check("to_hold_err", {30'd0, dmem_req, AccessErrM}, 32'h1);
        next();
        @(negedge clk);
        check("to_hold_cap_err", {30'd0, dmem_req, AccessErrM}, 32'h1);
        next();
        idle();
        @(negedge clk);
        next();
        @(negedge clk);
        check("to_hold_clear", 32'(AccessErrM), 32'd0);

        // Reset in WAIT abandons the transfer; a late ack is ignored
        next();
        drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("rw_wait", 32'(StallM), 32'd1);
        next();
        reset = 1'b1;
        @(negedge clk);
        check("rw_reset_req", {30'd0, dmem_req, StallM}, 32'h0);
        next();
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b1, 32'hAAAAAAAA);
        @(negedge clk);
        check("late_ack_req", {30'd0, dmem_req, StallM}, 32'h0);
        check("late_ack_rdata", ReadDataM, 32'd0);
        next();
        // A fresh access must start a full new timeout window from IDLE.
        drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_cyc%0d", i + 1), {30'd0, dmem_req, StallM}, 32'h3);
            next();
        end
        @(negedge clk);
        check("post_rst_to", 32'(AccessErrM), 32'd1);
        next();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
